// File: rtl/wb_pkg.sv
// Shared writeback-stage codes: load types, write-data sources and the PC reset value.
package wb_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LB  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LH  = 3'd4;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_LINK = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic        reg_write;
    logic [4:0]  a3;
    logic [1:0]  wd_sel;
    logic [2:0]  load_type;
    logic [31:0] alu_out;
    logic [31:0] dm_read;
  } wb_fields_t;

endpackage

// File: rtl/load_ext.sv
// Load-data extraction and sign/zero extension from an aligned 32-bit memory word.
module load_ext
  import wb_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (offset_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    // Low offset bit is ignored for halfwords; misalignment never reaches here.
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    case (load_type_i)
      LT_LBU:  data_o = {24'd0, byte_sel};
      LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LHU:  data_o = {16'd0, half_sel};
      LT_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// M-to-W pipeline register plus writeback data select driving the GRF write port.
// Define WB_FWD_EN to expose the W_Fwd* forwarding outputs.
module wb_stage
  import wb_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          WIDTH    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic [WIDTH-1:0]  M_PC,
  input  logic              M_RegWrite,
  input  logic [4:0]        M_A3,
  input  logic [1:0]        M_WDSel,
  input  logic [2:0]        M_LoadType,
  input  logic [WIDTH-1:0]  M_ALUOut,
  input  logic [WIDTH-1:0]  M_DMRead,
`ifdef WB_FWD_EN
  output logic              W_FwdValid,
  output logic [4:0]        W_FwdA3,
  output logic [WIDTH-1:0]  W_FwdData,
`endif
  output logic              W_GRFEn,
  output logic [4:0]        W_A3,
  output logic [WIDTH-1:0]  W_WD,
  output logic [WIDTH-1:0]  W_PC
);

  wb_fields_t fields_q, fields_d, bubble;
  logic [31:0] load_data;

  always_comb begin
    bubble    = '0;
    bubble.pc = PC_RESET;
  end

  always_comb begin
    fields_d = fields_q;
    if (flush) begin
      fields_d = bubble;
    end else if (en) begin
      fields_d.pc        = M_PC;
      fields_d.reg_write = M_RegWrite;
      fields_d.a3        = M_A3;
      fields_d.wd_sel    = M_WDSel;
      fields_d.load_type = M_LoadType;
      fields_d.alu_out   = M_ALUOut;
      fields_d.dm_read   = M_DMRead;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) fields_q <= bubble;
    else       fields_q <= fields_d;
  end

  load_ext u_load_ext (
    .word_i      (fields_q.dm_read),
    .offset_i    (fields_q.alu_out[1:0]),
    .load_type_i (fields_q.load_type),
    .data_o      (load_data)
  );

  always_comb begin
    case (fields_q.wd_sel)
      WD_ALU:  W_WD = fields_q.alu_out;
      WD_MEM:  W_WD = load_data;
      WD_LINK: W_WD = fields_q.pc + 32'd8;
      default: W_WD = '0;
    endcase
  end

  assign W_GRFEn = fields_q.reg_write && (fields_q.a3 != 5'd0);
  assign W_A3    = fields_q.a3;
  assign W_PC    = fields_q.pc;

`ifdef WB_FWD_EN
  assign W_FwdValid = W_GRFEn;
  assign W_FwdA3    = W_A3;
  assign W_FwdData  = W_WD;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: cycle-by-cycle model compare plus literal checks.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic [31:0] M_PC, M_ALUOut, M_DMRead;
  logic        M_RegWrite;
  logic [4:0]  M_A3;
  logic [1:0]  M_WDSel;
  logic [2:0]  M_LoadType;
  logic        W_GRFEn;
  logic [4:0]  W_A3;
  logic [31:0] W_WD, W_PC;
`ifdef WB_FWD_EN
  logic        W_FwdValid;
  logic [4:0]  W_FwdA3;
  logic [31:0] W_FwdData;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .M_PC(M_PC), .M_RegWrite(M_RegWrite), .M_A3(M_A3), .M_WDSel(M_WDSel),
    .M_LoadType(M_LoadType), .M_ALUOut(M_ALUOut), .M_DMRead(M_DMRead),
`ifdef WB_FWD_EN
    .W_FwdValid(W_FwdValid), .W_FwdA3(W_FwdA3), .W_FwdData(W_FwdData),
`endif
    .W_GRFEn(W_GRFEn), .W_A3(W_A3), .W_WD(W_WD), .W_PC(W_PC)
  );

  // Model: what the W outputs must show, computed straight from the captured inputs.
  logic        model_valid = 1'b0;
  logic        exp_en;
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd, exp_pc;

  function automatic logic [31:0] spec_wd(input logic [31:0] pc, input logic [1:0] sel,
                                          input logic [2:0] lt, input logic [31:0] alu,
                                          input logic [31:0] dm);
    logic [31:0] b, h, ld;
    b = (dm >> (8 * alu[1:0])) & 32'hFF;
    h = alu[1] ? (dm >> 16) : (dm & 32'hFFFF);
    case (lt)
      3'd1:    ld = b;
      3'd2:    ld = b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd3:    ld = h;
      3'd4:    ld = h[15] ? (h | 32'hFFFF_0000) : h;
      default: ld = dm;
    endcase
    case (sel)
      2'd0:    return alu;
      2'd1:    return ld;
      2'd2:    return pc + 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset || flush) begin
      exp_en <= 1'b0; exp_a3 <= 5'd0; exp_wd <= 32'd0; exp_pc <= 32'h0000_3000;
      if (reset) model_valid <= 1'b1;
    end else if (en) begin
      exp_en <= M_RegWrite && (M_A3 != 0);
      exp_a3 <= M_A3;
      exp_wd <= spec_wd(M_PC, M_WDSel, M_LoadType, M_ALUOut, M_DMRead);
      exp_pc <= M_PC;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_grfen", {31'd0, W_GRFEn}, {31'd0, exp_en});
      chk("model_a3", {27'd0, W_A3}, {27'd0, exp_a3});
      chk("model_wd", W_WD, exp_wd);
      chk("model_pc", W_PC, exp_pc);
`ifdef WB_FWD_EN
      chk("fwd_valid", {31'd0, W_FwdValid}, {31'd0, exp_en});
      chk("fwd_a3", {27'd0, W_FwdA3}, {27'd0, exp_a3});
      chk("fwd_data", W_FwdData, exp_wd);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [31:0] pc, input logic rw, input logic [4:0] a3,
                       input logic [1:0] sel, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] dm);
    M_PC = pc; M_RegWrite = rw; M_A3 = a3; M_WDSel = sel;
    M_LoadType = lt; M_ALUOut = alu; M_DMRead = dm;
  endtask

  typedef struct { logic [1:0] off; logic [2:0] lt; logic [31:0] wd; string name; } load_vec_t;
  load_vec_t lv [8];

  initial begin
    lv[0] = '{2'd3, 3'd2, 32'hFFFF_FF80, "lb_off3"};
    lv[1] = '{2'd3, 3'd1, 32'h0000_0080, "lbu_off3"};
    lv[2] = '{2'd0, 3'd4, 32'h0000_7F01, "lh_off0"};
    lv[3] = '{2'd2, 3'd4, 32'hFFFF_80FF, "lh_off2"};
    lv[4] = '{2'd2, 3'd3, 32'h0000_80FF, "lhu_off2"};
    lv[5] = '{2'd1, 3'd6, 32'h80FF_7F01, "lt6_word"};
    lv[6] = '{2'd1, 3'd2, 32'h0000_007F, "lb_off1"};
    lv[7] = '{2'd3, 3'd4, 32'hFFFF_80FF, "lh_off3"};

    reset = 1'b1; en = 1'b0; flush = 1'b0;
    set_m(32'h0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_grfen", {31'd0, W_GRFEn}, 32'd0);
    chk("rst_a3", {27'd0, W_A3}, 32'd0);
    chk("rst_wd", W_WD, 32'd0);
    chk("rst_pc", W_PC, 32'h0000_3000);
    $display("txn reset: pc=%h wd=%h", W_PC, W_WD);

    en = 1'b1;
    set_m(32'h3004, 1'b1, 5'd8, 2'd0, 3'd0, 32'h1234_5678, 32'h0);
    cyc();
    chk("alu_grfen", {31'd0, W_GRFEn}, 32'd1);
    chk("alu_a3", {27'd0, W_A3}, 32'd8);
    chk("alu_wd", W_WD, 32'h1234_5678);
    chk("alu_pc", W_PC, 32'h3004);
    $display("txn alu: a3=%0d wd=%h", W_A3, W_WD);

    foreach (lv[i]) begin
      set_m(32'h3008 + 4 * i, 1'b1, 5'd5, 2'd1, lv[i].lt, {30'h1000, lv[i].off}, 32'h80FF_7F01);
      cyc();
      chk(lv[i].name, W_WD, lv[i].wd);
      $display("txn load %s: wd=%h", lv[i].name, W_WD);
    end

    set_m(32'hFFFF_FFFC, 1'b1, 5'd31, 2'd2, 3'd0, 32'h0, 32'h0);
    cyc();
    chk("link_wd", W_WD, 32'h0000_0004);
    chk("link_grfen", {31'd0, W_GRFEn}, 32'd1);
    M_A3 = 5'd0;
    cyc();
    chk("zero_grfen", {31'd0, W_GRFEn}, 32'd0);
    chk("zero_wd", W_WD, 32'h0000_0004);
    $display("txn link: wd=%h en=%0d", W_WD, W_GRFEn);

    set_m(32'h3100, 1'b1, 5'd3, 2'd3, 3'd0, 32'hDEAD_BEEF, 32'h1);
    cyc();
    chk("rsvd_wd", W_WD, 32'd0);

    set_m(32'h3010, 1'b1, 5'd9, 2'd1, 3'd2, 32'h0000_0103, 32'h80FF_7F01);
    cyc();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_m(32'h4000 + k, 1'b1, 5'd20 + k, 2'd0, 3'd0, 32'hAAAA_0000 + k, 32'h5555_5555);
      cyc();
      chk("stall_wd", W_WD, 32'hFFFF_FF80);
      chk("stall_pc", W_PC, 32'h3010);
      chk("stall_a3", {27'd0, W_A3}, 32'd9);
    end
    $display("txn stall: pc=%h wd=%h", W_PC, W_WD);

    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_grfen", {31'd0, W_GRFEn}, 32'd0);
    chk("flush_pc", W_PC, 32'h3000);
    $display("txn flush: pc=%h", W_PC);

    en = 1'b1;
    set_m(32'h3200, 1'b1, 5'd7, 2'd0, 3'd0, 32'h0BAD_F00D, 32'h0);
    cyc();
    chk("pre_rst_wd", W_WD, 32'h0BAD_F00D);
    en = 1'b0; reset = 1'b1;
    cyc();
    chk("stall_rst_pc", W_PC, 32'h3000);
    chk("stall_rst_wd", W_WD, 32'd0);
    reset = 1'b0; en = 1'b1;
    cyc();
    flush = 1'b1; reset = 1'b1;
    cyc();
    flush = 1'b0; reset = 1'b0; en = 1'b0;
    chk("fr_grfen", {31'd0, W_GRFEn}, 32'd0);
    chk("fr_a3", {27'd0, W_A3}, 32'd0);
    chk("fr_wd", W_WD, 32'd0);
    chk("fr_pc", W_PC, 32'h3000);
    $display("txn flush+reset: pc=%h wd=%h", W_PC, W_WD);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
